core_ctrl: RTL and testbench

- Instruction sequencer for the systolic-array core; replaces the hand-timed stimulus bench with synthesizable control.
- For each of len_kij kernel positions it issues the 35-bit instruction stream that performs these steps in order:
  - kernel xmem->L0
  - L0->PE load
  - activation xmem->L0
  - execute
  - OFIFO->pmem write
- It then runs the accumulation pass (pmem read + acc) for len_onij outputs.
- It sits between the host/top level and the core's inst port.

---
 rtl/core_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_core_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/core_ctrl.sv
// rtl/core_ctrl.sv - instruction sequencer driving the systolic-array core inst port
module core_ctrl #(
   parameter int          row      = 8,
   parameter int          col      = 8,
   parameter int          len_nij  = 8,
   parameter int          len_kij  = 9,
   parameter int          len_onij = 16,
   parameter logic [10:0] KBASE    = 11'h400
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        start,
   input  logic                        mode,
   input  logic                        ofifo_valid,
   input  logic [10:0]                 acc_addr,
   output logic [$clog2(len_onij)-1:0] acc_o,
   output logic [$clog2(len_kij)-1:0]  acc_k,
   output logic [34:0]                 inst,
   output logic                        psum_clr,
   output logic                        out_strobe,
   output logic                        busy,
   output logic                        done
);

   localparam int EX_LEN = 1 + len_nij + row + col;
   localparam int CW     = $clog2(EX_LEN + 1);
   localparam int KW     = $clog2(len_kij);
   localparam int OW     = $clog2(len_onij);

   // Core instruction bit map
   localparam int B_ACC      = 33;
   localparam int B_CEN_PMEM = 32;
   localparam int B_WEN_PMEM = 31;
   localparam int B_CEN_XMEM = 19;
   localparam int B_OFIFO_RD = 6;
   localparam int B_L0_RD    = 3;
   localparam int B_L0_WR    = 2;
   localparam int B_EXECUTE  = 1;
   localparam int B_LOAD     = 0;

   localparam logic [34:0] IDLE_WORD = 35'h1800C0000;

   typedef enum logic [3:0] {
      S_IDLE, S_WL0, S_WG, S_WLD, S_WF, S_AL0, S_AG, S_EX,
      S_ES, S_OFW, S_PW, S_ACLR, S_ARD, S_AEND
   } state_t;

   state_t        state;
   logic [CW-1:0] i;
   logic [KW-1:0] kij;
   logic          mode_r;
   logic          acc_adv;
   logic [34:0]   word;
   logic [10:0]   xmem_k_addr;
   logic [10:0]   pmem_w_addr;

   assign xmem_k_addr = KBASE + 11'(kij * col) + 11'(i);
   assign pmem_w_addr = 11'(kij * len_nij) + 11'(i);

   // Instruction word for the current state/step; registered into inst below
   always_comb begin
      word     = IDLE_WORD;
      // the first word of a run already carries the newly sampled mode
      word[34] = (state == S_IDLE && start && !done) ? mode : mode_r;
      case (state)
         S_WL0: begin
            word[B_CEN_XMEM] = 1'b0;
            word[B_L0_WR]    = 1'b1;
            word[17:7]       = xmem_k_addr;
         end
         S_WLD: begin
            word[B_L0_RD] = 1'b1;
            word[B_LOAD]  = (i != '0);
         end
         S_AL0: begin
            word[B_CEN_XMEM] = 1'b0;
            word[B_L0_WR]    = 1'b1;
            word[17:7]       = 11'(i);
         end
         S_EX: begin
            word[B_L0_RD]   = 1'b1;
            word[B_EXECUTE] = (i != '0);
         end
         S_OFW: word[B_OFIFO_RD] = ofifo_valid;
         S_PW: begin
            word[B_OFIFO_RD]  = 1'b1;
            word[B_CEN_PMEM]  = 1'b0;
            word[B_WEN_PMEM]  = 1'b0;
            word[30:20]       = pmem_w_addr;
         end
         S_ARD: begin
            if (i < CW'(len_kij)) begin
               word[B_CEN_PMEM] = 1'b0;
               word[30:20]      = acc_addr;
            end
            word[B_ACC] = (i != '0);
         end
         default: ;
      endcase
   end

   // Sequencer FSM with registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         inst       <= IDLE_WORD;
         psum_clr   <= 1'b0;
         out_strobe <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         i          <= '0;
         kij        <= '0;
         acc_o      <= '0;
         acc_k      <= '0;
         mode_r     <= 1'b0;
         acc_adv    <= 1'b0;
      end else begin
         inst       <= word;
         psum_clr   <= 1'b0;
         out_strobe <= 1'b0;
         done       <= 1'b0;
         case (state)
            S_IDLE: begin
               // the done cycle itself does not accept a new start
               if (start && !done) begin
                  mode_r <= mode;
                  kij    <= '0;
                  i      <= '0;
                  busy   <= 1'b1;
                  state  <= S_WL0;
               end
            end
            S_WL0: begin
               if (i == CW'(col - 1)) begin i <= '0; state <= S_WG; end
               else i <= i + 1'b1;
            end
            S_WG: state <= S_WLD;
            S_WLD: begin
               if (i == CW'(col)) begin i <= '0; state <= S_WF; end
               else i <= i + 1'b1;
            end
            S_WF: state <= S_AL0;
            S_AL0: begin
               if (i == CW'(len_nij - 1)) begin i <= '0; state <= S_AG; end
               else i <= i + 1'b1;
            end
            S_AG: state <= S_EX;
            S_EX: begin
               if (i == CW'(EX_LEN - 1)) begin i <= '0; state <= S_ES; end
               else i <= i + 1'b1;
            end
            S_ES: state <= S_OFW;
            S_OFW: begin
               if (ofifo_valid) begin i <= '0; state <= S_PW; end
            end
            S_PW: begin
               if (i == CW'(len_nij)) begin
                  i <= '0;
                  if (kij != KW'(len_kij - 1)) begin
                     kij   <= kij + 1'b1;
                     state <= S_WL0;
                  end else begin
                     acc_o   <= '0;
                     acc_adv <= 1'b0;
                     state   <= S_ACLR;
                  end
               end else i <= i + 1'b1;
            end
            S_ACLR: begin
               // acc_o advances here so it still names the finished output during out_strobe
               psum_clr <= 1'b1;
               if (acc_adv) acc_o <= acc_o + 1'b1;
               acc_adv <= 1'b0;
               acc_k   <= '0;
               i       <= '0;
               state   <= S_ARD;
            end
            S_ARD: begin
               if (i == CW'(len_kij)) begin
                  i     <= '0;
                  state <= S_AEND;
               end else begin
                  i <= i + 1'b1;
                  if (i < CW'(len_kij - 1)) acc_k <= acc_k + 1'b1;
               end
            end
            S_AEND: begin
               out_strobe <= 1'b1;
               if (acc_o != OW'(len_onij - 1)) begin
                  acc_adv <= 1'b1;
                  state   <= S_ACLR;
               end else begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_core_ctrl.sv
// tb/tb_core_ctrl.sv - self-checking bench for core_ctrl
module tb_core_ctrl;

   logic        clk = 1'b0;
   logic        reset, start, mode, ofifo_valid;
   logic [10:0] acc_addr;
   logic [3:0]  acc_o;
   logic [3:0]  acc_k;
   logic [34:0] inst;
   logic        psum_clr, out_strobe, busy, done;

   localparam logic [34:0] IW = 35'h1800C0000;

   int total = 0;
   int bad   = 0;

   logic [34:0] inst_log [0:1023];
   logic [3:0]  flg_log  [0:1023];
   logic [3:0]  acco_log [0:1023];

   typedef struct {
      int          t;
      logic [34:0] inst;
      logic [3:0]  flg;
   } vec_t;

   vec_t vecs [24];

   always #5 clk = ~clk;

   assign acc_addr = 11'(acc_o) * 11'd9 + 11'(acc_k);

   core_ctrl dut (
      .clk(clk), .reset(reset), .start(start), .mode(mode),
      .ofifo_valid(ofifo_valid), .acc_addr(acc_addr),
      .acc_o(acc_o), .acc_k(acc_k), .inst(inst),
      .psum_clr(psum_clr), .out_strobe(out_strobe), .busy(busy), .done(done)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Pulse start, then log outputs once per cycle (t=0 is the cycle after the start edge)
   task automatic run(input logic m, input bit stall, input bit toggle, input bit extra,
                      input int rst_at, output int len);
      len = -1;
      @(negedge clk);
      mode = m; start = 1'b1; ofifo_valid = 1'b1;
      for (int t = 0; t < 1000; t++) begin
         @(negedge clk);
         inst_log[t] = inst;
         flg_log[t]  = {busy, psum_clr, out_strobe, done};
         acco_log[t] = acc_o;
         start = 1'b0;
         if (rst_at >= 0 && t == rst_at + 1) begin len = t; break; end
         if (done) begin
            if (extra) start = 1'b1;
            len = t;
            break;
         end
         if (extra && t < 700 && (t % 97) == 5) start = 1'b1;
         if (toggle) mode = ~mode;
         ofifo_valid = !(stall && t >= 246 && t < 266);
         if (t == rst_at) reset = 1'b1;
      end
   endtask

   initial begin
      int len;
      int errs;
      int n_l0wr, n_load, n_exec, n_pw, n_pclr, n_ostr, n_done, n_mode;

      vecs[0]  = '{0,   IW,            4'b1000};
      vecs[1]  = '{1,   35'h180060004, 4'b1000};
      vecs[2]  = '{8,   35'h180060384, 4'b1000};
      vecs[3]  = '{9,   IW,            4'b1000};
      vecs[4]  = '{10,  35'h1800C0008, 4'b1000};
      vecs[5]  = '{11,  35'h1800C0009, 4'b1000};
      vecs[6]  = '{20,  35'h180040004, 4'b1000};
      vecs[7]  = '{27,  35'h180040384, 4'b1000};
      vecs[8]  = '{29,  35'h1800C0008, 4'b1000};
      vecs[9]  = '{30,  35'h1800C000A, 4'b1000};
      vecs[10] = '{53,  35'h1800C000A, 4'b1000};
      vecs[11] = '{54,  IW,            4'b1000};
      vecs[12] = '{55,  35'h1800C0040, 4'b1000};
      vecs[13] = '{56,  35'h0000C0040, 4'b1000};
      vecs[14] = '{64,  35'h0008C0040, 4'b1000};
      vecs[15] = '{65,  35'h180060404, 4'b1000};
      vecs[16] = '{576, 35'h0048C0040, 4'b1000};
      vecs[17] = '{577, IW,            4'b1100};
      vecs[18] = '{578, 35'h0800C0000, 4'b1000};
      vecs[19] = '{579, 35'h2801C0000, 4'b1000};
      vecs[20] = '{587, 35'h3800C0000, 4'b1000};
      vecs[21] = '{588, IW,            4'b1010};
      vecs[22] = '{766, 35'h288FC0000, 4'b1000};
      vecs[23] = '{768, IW,            4'b0011};

      // 1: reset and idle
      reset = 1'b1; start = 1'b0; mode = 1'b0; ofifo_valid = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check("reset_idle", {inst, busy, done, psum_clr, out_strobe, acc_o, acc_k},
               {IW, 4'b0000, 4'd0, 4'd0});
      end

      // 2: default run, spot vectors then per-kij decoding
      run(1'b0, 1'b0, 1'b0, 1'b0, -1, len);
      check("run_len", len, 768);
      for (int v = 0; v < 24; v++)
         check($sformatf("vec_t%0d", vecs[v].t),
               {inst_log[vecs[v].t], flg_log[vecs[v].t]}, {vecs[v].inst, vecs[v].flg});
      n_l0wr = 0; n_load = 0; n_exec = 0; n_pw = 0;
      n_pclr = 0; n_ostr = 0; n_done = 0; n_mode = 0;
      for (int t = 0; t <= 768; t++) begin
         n_l0wr += int'(inst_log[t][2]);
         n_load += int'(inst_log[t][0]);
         n_exec += int'(inst_log[t][1]);
         n_pw   += int'(!inst_log[t][32] && !inst_log[t][31]);
         n_mode += int'(inst_log[t][34]);
         n_pclr += int'(flg_log[t][2]);
         n_ostr += int'(flg_log[t][1]);
         n_done += int'(flg_log[t][0]);
      end
      check("cnt_l0_wr", n_l0wr, 144);
      check("cnt_load", n_load, 72);
      check("cnt_execute", n_exec, 216);
      check("cnt_pmem_wr", n_pw, 81);
      check("cnt_psum_clr", n_pclr, 16);
      check("cnt_out_strobe", n_ostr, 16);
      check("cnt_done", n_done, 1);
      check("cnt_mode_bit", n_mode, 0);
      for (int k = 0; k < 9; k++) begin
         errs = 0;
         for (int s = 0; s < 8; s++) begin
            if (inst_log[1 + 64*k + s][17:7] !== 11'(32'h400 + 8*k + s)) errs++;
            if (inst_log[20 + 64*k + s][17:7] !== 11'(s)) errs++;
         end
         for (int s = 0; s < 9; s++)
            if (inst_log[56 + 64*k + s][30:20] !== 11'(8*k + s)) errs++;
         check($sformatf("kij%0d_addr", k), errs, 0);
      end

      // 4: accumulation addressing, acc window, clear/strobe pairing
      for (int m = 0; m < 16; m++) begin
         errs = 0;
         for (int j = 0; j < 9; j++)
            if (inst_log[578 + 12*m + j][32] !== 1'b0 ||
                inst_log[578 + 12*m + j][30:20] !== 11'(9*m + j)) errs++;
         for (int j = 0; j <= 10; j++)
            if (inst_log[578 + 12*m + j][33] !== (j >= 1 && j <= 9)) errs++;
         if (flg_log[577 + 12*m][2] !== 1'b1) errs++;
         if (flg_log[588 + 12*m][1] !== 1'b1 || acco_log[588 + 12*m] !== 4'(m)) errs++;
         check($sformatf("acc_out%0d", m), errs, 0);
      end

      // 3: ofifo stall after ES of kij 3
      run(1'b0, 1'b1, 1'b0, 1'b0, -1, len);
      check("stall_len", len, 788);
      errs = 0;
      for (int t = 247; t <= 266; t++)
         if (inst_log[t] !== IW) errs++;
      check("stall_idle_words", errs, 0);
      check("stall_ofifo_rd", inst_log[267], 35'h1800C0040);
      check("stall_pw_first", inst_log[268], 35'h0018C0040);

      // 5: mode=1 held for the run, repeated starts ignored, start on done ignored
      run(1'b1, 1'b0, 1'b1, 1'b1, -1, len);
      check("mode1_len", len, 768);
      errs = 0;
      for (int t = 0; t <= 768; t++)
         if (inst_log[t][34] !== 1'b1) errs++;
      check("mode1_bit", errs, 0);
      @(negedge clk);
      start = 1'b0;
      check("start_on_done", {busy, inst}, {1'b0, 35'h5800C0000});

      // 6: reset during EX of kij 5, then a clean full run
      run(1'b0, 1'b0, 1'b0, 1'b0, 355, len);
      check("abort_len", len, 356);
      check("abort_state", {inst_log[356], flg_log[356]}, {IW, 4'b0000});
      reset = 1'b0;
      errs = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0) errs++;
      end
      check("abort_quiet", errs, 0);
      run(1'b0, 1'b0, 1'b0, 1'b0, -1, len);
      check("rerun_len", len, 768);
      check("rerun_kij0", inst_log[1], 35'h180060004);
      check("rerun_kij1", inst_log[65], 35'h180060404);
      check("rerun_done", flg_log[768], 4'b0011);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
